serial_subtractor: RTL and testbench

Bit-serial registered subtractor computing `d = a - b - bin` for WIDTH-bit unsigned operands, LSB first, one bit per clock. It is the inverse companion of the team's 8-bit ripple adder: given a sum and one operand, it recovers the other operand. It also serves as the sequential reference for mapping small arithmetic datapaths through VTR. It sits beside the adder in the `sequential` target-design set, with a start/done handshake toward the surrounding test harness.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   sub_state_t   : FSM state encoding (IDLE, RUN)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : bit-counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor (x - y - bin).
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when they are equal and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial registered subtractor: d = (a - b - bin) mod 2^WIDTH, LSB first,
// one bit per clock, with a start/busy/done handshake.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request an operation (sampled only when idle)
//   a, b, bin  : minuend, subtrahend, borrow-in (captured on the accepting edge)
//   busy       : operation in progress
//   done       : one-cycle pulse when d/bout are updated
//   d, bout    : difference and borrow-out of the last completed operation
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fs_d, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = fs_bout;
                res_d    = res_next;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    d_d     = res_next;
                    bout_d  = fs_bout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [7:0] ref_d(input logic [7:0] ta, input logic [7:0] tb,
                                         input logic tc);
        int diff;
        diff = int'(ta) - int'(tb) - int'(tc);
        return diff[7:0];
    endfunction

    function automatic logic ref_bout(input logic [7:0] ta, input logic [7:0] tb,
                                      input logic tc);
        return int'(ta) < (int'(tb) + int'(tc));
    endfunction

    // Wait for done after an accepting edge; lat = cycles until done, 0 if never.
    task automatic wait_done(output int lat, input bit chk_busy);
        lat = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (chk_busy) check_eq("busy_run", 32'(busy), 32'd1);
        end
    endtask

    task automatic check_result(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [7:0] inv;
        check_eq("d", 32'(d), 32'(ref_d(ta, tb, tc)));
        check_eq("bout", 32'(bout), 32'(ref_bout(ta, tb, tc)));
        inv = d + tb + 8'(tc);
        check_eq("inverse", 32'(inv), 32'(ta));
    endtask

    // One operation; poke re-asserts start with other operands mid-run.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input bit poke, input bit chk_busy);
        int lat;
        bit extra;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tc;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check_eq("busy_accept", 32'(busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (poke && i == 3) begin
                start = 1'b1; a = ~ta; b = ta; bin = ~tc;
            end
            if (poke && i == 5) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (chk_busy) check_eq("busy_run", 32'(busy), 32'd1);
        end
        check_eq("latency", 32'(lat), 32'(WIDTH));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_result(ta, tb, tc);
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(done), 32'd0);
        if (poke) begin
            extra = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done || busy) extra = 1'b1;
            end
            check_eq("no_second_op", 32'(extra), 32'd0);
        end
    endtask

    task automatic back_to_back();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic       ec [4];
        int lat;
        int prev;
        for (int i = 0; i < 4; i++) begin
            ea[i] = 8'($urandom); eb[i] = 8'($urandom); ec[i] = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b1; a = ea[0]; b = eb[0]; bin = ec[0];
        @(posedge clk); #1;
        a = ea[1]; b = eb[1]; bin = ec[1];
        prev = 0;
        for (int idx = 0; idx < 4; idx++) begin
            wait_done(lat, 1'b0);
            check_eq("b2b_found", 32'(lat != 0), 32'd1);
            check_result(ea[idx], eb[idx], ec[idx]);
            if (idx > 0) check_eq("b2b_spacing", 32'(cyc - prev), 32'(WIDTH + 1));
            prev = cyc;
            if (idx == 3) begin
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
                check_eq("b2b_accept", 32'(busy), 32'd1);
                if (idx + 2 < 4) begin
                    a = ea[idx + 2]; b = eb[idx + 2]; bin = ec[idx + 2];
                end
            end
        end
        @(posedge clk); #1;
        check_eq("b2b_done_low", 32'(done), 32'd0);
    endtask

    task automatic reset_mid_run();
        int lat;
        do_op(8'h50, 8'h20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h9C; b = 8'h31; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_d", 32'(d), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
        // start presented during reset is taken on the first edge after release.
        start = 1'b1; a = 8'h3A; b = 8'hC5; bin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("release_accept", 32'(busy), 32'd1);
        wait_done(lat, 1'b1);
        check_eq("release_latency", 32'(lat), 32'(WIDTH));
        check_result(8'h3A, 8'hC5, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_d", 32'(d), 32'd0);
        check_eq("reset_bout", 32'(bout), 32'd0);
        #22;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h50, 8'h20, 1'b0, 1'b0, 1'b1);
        do_op(8'h20, 8'h50, 1'b0, 1'b0, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);

        back_to_back();
        reset_mid_run();

        for (int n = 0; n < 1000; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
